bram_ring_controller: RTL and testbench

Flow controller for the 16K-word BRAM ring written by the FIFO-to-BRAM path and drained by the PS. Tracks write and read positions, maintains the fill level and gates the acquisition datapath through a packet-granular `write_allow`. Raises a packet-aligned interrupt at a PS-programmed fill threshold and records overflow. Sits between the FIFO-BRAM interface (commit pulses) and the control/status register bank (read pointer, threshold, status).

---
 rtl/bram_ring_controller.sv | 111 +++++++++++
 tb/tb_bram_ring_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bram_ring_controller.sv
// Flow controller for the BRAM acquisition ring: tracks fill from commits and
// PS releases, gates packet starts with write_allow, raises irq, records overflow.
module bram_ring_controller #(
  parameter int DEPTH_WORDS    = 16384,
  parameter int PTR_W          = 14,
  parameter int HEADROOM_WORDS = 128
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             word_commit,
  input  logic             pkt_end,
  input  logic [PTR_W-1:0] rd_ptr,
  input  logic             rd_ptr_wr,
  input  logic [PTR_W:0]   irq_threshold,
  input  logic             irq_ack,
  input  logic             err_clear,
  output logic             write_allow,
  output logic             irq,
  output logic [PTR_W:0]   fill_level,
  output logic             overflow,
  output logic             rd_error,
  output logic [15:0]      dropped_words,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2, OVF = 2'd3} state_t;

  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(DEPTH_WORDS);
  localparam logic [PTR_W:0] HEAD_L  = (PTR_W+1)'(HEADROOM_WORDS);
  localparam logic [PTR_W:0] HEAD2_L = (PTR_W+1)'(2*HEADROOM_WORDS);

  state_t           st;
  logic [PTR_W-1:0] rd_shadow, delta, delta_acc;
  logic [PTR_W:0]   fill, fill_next, free;
  logic             idle_hold, full, rel_ok, rel_bad, commit_ok, ovf_evt, irq_set;

  always_comb begin
    idle_hold = !enable || (st == IDLE);
    full      = (fill == DEPTH_L);
    free      = DEPTH_L - fill;
    // Pointer difference wraps naturally in PTR_W bits.
    delta     = rd_ptr - rd_shadow;
    rel_ok    = rd_ptr_wr && ({1'b0, delta} <= fill) && !idle_hold;
    rel_bad   = rd_ptr_wr && ({1'b0, delta} >  fill) && !idle_hold;
    delta_acc = rel_ok ? delta : '0;
    commit_ok = word_commit && !full && !idle_hold;
    ovf_evt   = word_commit &&  full && !idle_hold;
    fill_next = fill + (PTR_W+1)'(commit_ok) - {1'b0, delta_acc};
    irq_set   = pkt_end && (irq_threshold != '0) && (fill_next >= irq_threshold) && !idle_hold;
  end

  // FSM decides on the registered fill, so state trails fill_level by a cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st          <= IDLE;
      write_allow <= 1'b0;
    end else begin
      state_t nxt;
      nxt = st;
      if (!enable) nxt = IDLE;
      else begin
        case (st)
          IDLE: nxt = RUN;
          RUN:  if (ovf_evt) nxt = OVF; else if (free < HEAD_L) nxt = HOLD;
          HOLD: if (ovf_evt) nxt = OVF; else if (free >= HEAD2_L) nxt = RUN;
          OVF:  if (err_clear) nxt = (fill < DEPTH_L - HEAD2_L) ? RUN : HOLD;
          default: nxt = IDLE;
        endcase
      end
      st          <= nxt;
      write_allow <= (nxt == RUN);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_shadow     <= '0;
      fill          <= '0;
      irq           <= 1'b0;
      overflow      <= 1'b0;
      rd_error      <= 1'b0;
      dropped_words <= '0;
    end else begin
      if (idle_hold) begin
        rd_shadow <= '0;
        fill      <= '0;
        irq       <= 1'b0;
      end else begin
        if (rel_ok) rd_shadow <= rd_ptr;
        fill <= fill_next;
        if (irq_set)      irq <= 1'b1;
        else if (irq_ack) irq <= 1'b0;
      end

      if (err_clear) begin
        overflow      <= ovf_evt;
        rd_error      <= rel_bad;
        dropped_words <= {15'd0, ovf_evt};
      end else begin
        if (ovf_evt) overflow <= 1'b1;
        if (rel_bad) rd_error <= 1'b1;
        if (ovf_evt && dropped_words != 16'hFFFF) dropped_words <= dropped_words + 16'd1;
      end
    end
  end

  assign fill_level = fill;
  assign state      = st;

endmodule

// File: tb/tb_bram_ring_controller.sv
// Directed bench for bram_ring_controller: hand-computed fill/state/flag values.
module tb_bram_ring_controller;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0, word_commit = 1'b0, pkt_end = 1'b0;
  logic [13:0] rd_ptr = '0;
  logic        rd_ptr_wr = 1'b0;
  logic [14:0] irq_threshold = '0;
  logic        irq_ack = 1'b0, err_clear = 1'b0;
  logic        write_allow, irq, overflow, rd_error;
  logic [14:0] fill_level;
  logic [15:0] dropped_words;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  bram_ring_controller dut (
    .clk(clk), .rstn(rstn), .enable(enable), .word_commit(word_commit),
    .pkt_end(pkt_end), .rd_ptr(rd_ptr), .rd_ptr_wr(rd_ptr_wr),
    .irq_threshold(irq_threshold), .irq_ack(irq_ack), .err_clear(err_clear),
    .write_allow(write_allow), .irq(irq), .fill_level(fill_level),
    .overflow(overflow), .rd_error(rd_error), .dropped_words(dropped_words),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commits(input int n);
    word_commit = 1'b1;
    repeat (n) step();
    word_commit = 1'b0;
  endtask

  task automatic release_to(input logic [13:0] p);
    rd_ptr = p; rd_ptr_wr = 1'b1;
    step();
    rd_ptr_wr = 1'b0;
  endtask

  task automatic restart();
    enable = 1'b0; step();
    enable = 1'b1; step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_wa"},    32'(write_allow), 0);
    chk({tag, "_fill"},  32'(fill_level), 0);
    chk({tag, "_irq"},   32'(irq), 0);
    chk({tag, "_ovf"},   32'(overflow), 0);
    chk({tag, "_rderr"}, 32'(rd_error), 0);
    chk({tag, "_drop"},  32'(dropped_words), 0);
  endtask

  initial begin
    #3;
    chk_all_zero("reset");
    #10 rstn = 1'b1;

    // basic fill and release
    enable = 1'b1; step();
    chk("start_state", 32'(state), 1);
    commits(100);
    chk("fill_100", 32'(fill_level), 100);
    release_to(14'd40);
    chk("fill_60", 32'(fill_level), 60);
    step();
    chk("basic_state", 32'(state), 1);
    chk("basic_wa", 32'(write_allow), 1);

    // hold hysteresis
    commits(16197);
    chk("fill_16257", 32'(fill_level), 16257);
    step();
    chk("hold_state", 32'(state), 2);
    chk("hold_wa", 32'(write_allow), 0);
    release_to(14'd168);
    chk("fill_16129", 32'(fill_level), 16129);
    step(); step();
    chk("hold_16129", 32'(state), 2);
    release_to(14'd169);
    chk("fill_16128", 32'(fill_level), 16128);
    step();
    chk("run_16128", 32'(state), 1);
    chk("run_wa", 32'(write_allow), 1);

    // overflow
    commits(256);
    chk("fill_full", 32'(fill_level), 16384);
    commits(3);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_drop", 32'(dropped_words), 3);
    chk("ovf_state", 32'(state), 3);
    chk("ovf_fill", 32'(fill_level), 16384);
    chk("ovf_wa", 32'(write_allow), 0);
    err_clear = 1'b1; step(); err_clear = 1'b0;
    chk("clr_state", 32'(state), 2);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_drop", 32'(dropped_words), 0);

    // disable clears fill
    enable = 1'b0; step();
    chk("dis_state", 32'(state), 0);
    chk("dis_fill", 32'(fill_level), 0);
    chk("dis_wa", 32'(write_allow), 0);
    enable = 1'b1; step();

    // interrupt
    irq_threshold = 15'd50;
    commits(48);
    word_commit = 1'b1; pkt_end = 1'b1; step(); word_commit = 1'b0; pkt_end = 1'b0;
    chk("irq_fill49", 32'(fill_level), 49);
    chk("irq_below", 32'(irq), 0);
    commits(24);
    word_commit = 1'b1; pkt_end = 1'b1; step(); word_commit = 1'b0; pkt_end = 1'b0;
    chk("irq_fill74", 32'(fill_level), 74);
    chk("irq_set", 32'(irq), 1);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("irq_ack", 32'(irq), 0);
    word_commit = 1'b1; pkt_end = 1'b1; irq_ack = 1'b1; step();
    word_commit = 1'b0; pkt_end = 1'b0; irq_ack = 1'b0;
    chk("irq_set_wins", 32'(irq), 1);
    irq_ack = 1'b1; irq_threshold = '0; step(); irq_ack = 1'b0;
    chk("irq_cleared", 32'(irq), 0);

    // read error and simultaneity
    restart();
    commits(10);
    release_to(14'd20);
    chk("rderr_flag", 32'(rd_error), 1);
    chk("rderr_fill", 32'(fill_level), 10);
    err_clear = 1'b1; step(); err_clear = 1'b0;
    chk("rderr_clr", 32'(rd_error), 0);
    word_commit = 1'b1; release_to(14'd4); word_commit = 1'b0;
    chk("simul_fill7", 32'(fill_level), 7);

    // pointer wrap
    restart();
    commits(16380);
    release_to(14'd16380);
    chk("wrap_drain", 32'(fill_level), 0);
    commits(10);
    release_to(14'd2);
    chk("wrap_fill4", 32'(fill_level), 4);

    // async reset mid-run with flags and irq set
    release_to(14'd100);
    irq_threshold = 15'd1;
    word_commit = 1'b1; pkt_end = 1'b1; step(); word_commit = 1'b0; pkt_end = 1'b0;
    irq_threshold = '0;
    step();
    chk("pre_rst_rderr", 32'(rd_error), 1);
    chk("pre_rst_irq", 32'(irq), 1);
    chk("pre_rst_fill", 32'(fill_level), 5);
    chk("pre_rst_state", 32'(state), 1);
    #2 rstn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    step();
    chk("resume_state", 32'(state), 1);
    chk("resume_fill", 32'(fill_level), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
